// File: rtl/wb_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_mux_pkg
//  Description : Shared types and constants for the Wishbone slave mux:
//                FSM state encoding, error-response data word, error-type
//                encodings, default base address and a response helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_mux_pkg;

    // Transaction FSM: one outstanding transfer at a time.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } wb_mux_state_e;

    // Read data returned with an error acknowledge.
    localparam logic [31:0] WB_ERR_DATA = 32'hDEAD_BEEF;

    // Error-log type encodings.
    localparam logic ERR_TYP_DECODE = 1'b0;
    localparam logic ERR_TYP_TMO    = 1'b1;

    // Default user-area window selected by adr[31:24].
    localparam logic [7:0] DEFAULT_BASE_ADDR = 8'h30;

    // Data word returned on a successful transfer: writes return zero so the
    // master never sees stale target read data on a write ack.
    function automatic logic [31:0] ok_rsp_data(input logic we,
                                                input logic [31:0] rd);
        return we ? 32'h0 : rd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_mux_tmo_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : wb_mux_tmo_cnt
//  Description : Target-access timeout counter. Counts enabled cycles since
//                the last clear; expire_o flags the TMO_CYC-th enabled cycle
//                so the caller can leave the access on that same edge.
//  Ports       : clk_i     - clock
//                rst_n_i   - asynchronous active-low reset
//                clr_i     - synchronous clear (dominates enable)
//                en_i      - count this cycle
//                expire_o  - this enabled cycle is the last one allowed
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_mux_tmo_cnt #(
    parameter int TMO_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TMO_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_W'(TMO_CYC))) begin
            // Saturate rather than wrap in case the caller keeps enabling.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of enabled cycles already completed, so the
    // TMO_CYC-th enabled cycle is the one where cnt_q == TMO_CYC-1.
    assign expire_o = en_i && (cnt_q == CNT_W'(TMO_CYC - 1));

endmodule
`default_nettype wire

// File: rtl/wb_slave_mux.sv
`default_nettype none
// ============================================================================
//  Module      : wb_slave_mux
//  Description : Wishbone 1:N bridge. Decodes one 32-bit master into NUM_SLV
//                targets by adr[SEL_LSB +: SLV_IDX_W] inside the adr[31:24]
//                == BASE_ADDR window, one transfer outstanding. Registers the
//                response, error-acks unmapped addresses and times out
//                targets that never acknowledge.
//  Option      : `define WB_SLAVE_MUX_ERR_LOG_EN adds a sticky error log
//                (err_clr_i, err_vld_o, err_adr_o, err_typ_o).
//  Ports       : wb_clk_i, wb_rst_n        - clock, async active-low reset
//                wbm_*_i / wbm_*_o         - master-side Wishbone
//                wbs_cyc_o, wbs_stb_o      - one-hot target cycle/strobe
//                wbs_we/sel/adr/dat_o      - registered request, shared
//                wbs_dat_i, wbs_ack_i      - per-target read data / ack
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_slave_mux
    import wb_mux_pkg::*;
#(
    parameter int         NUM_SLV   = 4,
    parameter int         SLV_IDX_W = 2,
    parameter int         SEL_LSB   = 16,
    parameter logic [7:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int         TMO_CYC   = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n,
    input  logic                    wbm_cyc_i,
    input  logic                    wbm_stb_i,
    input  logic                    wbm_we_i,
    input  logic [3:0]              wbm_sel_i,
    input  logic [31:0]             wbm_adr_i,
    input  logic [31:0]             wbm_dat_i,
    output logic                    wbm_ack_o,
    output logic [31:0]             wbm_dat_o,
    output logic                    wbm_err_o,
    output logic [NUM_SLV-1:0]      wbs_cyc_o,
    output logic [NUM_SLV-1:0]      wbs_stb_o,
    output logic                    wbs_we_o,
    output logic [3:0]              wbs_sel_o,
    output logic [31:0]             wbs_adr_o,
    output logic [31:0]             wbs_dat_o,
    input  logic [NUM_SLV*32-1:0]   wbs_dat_i,
    input  logic [NUM_SLV-1:0]      wbs_ack_i
`ifdef WB_SLAVE_MUX_ERR_LOG_EN
    ,
    input  logic                    err_clr_i,
    output logic                    err_vld_o,
    output logic [31:0]             err_adr_o,
    output logic                    err_typ_o
`endif
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wb_mux_state_e          state_q, state_d;
    logic [SLV_IDX_W-1:0]   tgt_q,   tgt_d;
    logic                   we_q,    we_d;
    logic [3:0]             sel_q,   sel_d;
    logic [31:0]            adr_q,   adr_d;
    logic [31:0]            dat_q,   dat_d;
    logic [31:0]            rsp_dat_q, rsp_dat_d;   // response staged for RESP
    logic                   rsp_err_q, rsp_err_d;
    logic                   ack_q,   ack_d;
    logic [31:0]            mdat_q,  mdat_d;
    logic                   merr_q,  merr_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                   w_req;
    logic [SLV_IDX_W-1:0]   w_req_idx;
    logic                   w_dec_err;

    // ack_q gates new requests: in the cycle wbm_ack_o is high the master
    // still holds stb, and it only drops it on the following edge.
    assign w_req     = wbm_cyc_i && wbm_stb_i && !ack_q;
    assign w_req_idx = wbm_adr_i[SEL_LSB +: SLV_IDX_W];
    assign w_dec_err = (wbm_adr_i[31:24] != BASE_ADDR) ||
                       ({{(32-SLV_IDX_W){1'b0}}, w_req_idx} >= 32'(NUM_SLV));

    // ------------------------------------------------------------------
    // Selected-target mux: one-hot select, its ack and its read data.
    // Acks from every other target are simply not looked at.
    // ------------------------------------------------------------------
    logic [NUM_SLV-1:0]     w_sel_oh;
    logic                   w_tgt_ack;
    logic [31:0]            w_tgt_dat;

    always_comb begin
        w_sel_oh  = '0;
        w_tgt_ack = 1'b0;
        w_tgt_dat = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (tgt_q == SLV_IDX_W'(k)) begin
                w_sel_oh[k] = 1'b1;
                w_tgt_ack   = wbs_ack_i[k];
                w_tgt_dat   = wbs_dat_i[k*32 +: 32];
            end
        end
    end

    // ------------------------------------------------------------------
    // Timeout counter: runs only while in ACCESS, cleared everywhere else
    // so each access starts from zero.
    // ------------------------------------------------------------------
    logic w_in_access;
    logic w_tmo_expire;

    assign w_in_access = (state_q == ST_ACCESS);

    wb_mux_tmo_cnt #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo_cnt (
        .clk_i    (wb_clk_i),
        .rst_n_i  (wb_rst_n),
        .clr_i    (!w_in_access),
        .en_i     (w_in_access),
        .expire_o (w_tmo_expire)
    );

    // ------------------------------------------------------------------
    // FSM next state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        ack_d     = 1'b0;
        mdat_d    = '0;
        merr_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    tgt_d = w_req_idx;
                    we_d  = wbm_we_i;
                    sel_d = wbm_sel_i;
                    adr_d = wbm_adr_i;
                    dat_d = wbm_dat_i;
                    if (w_dec_err) begin
                        state_d   = ST_RESP;
                        rsp_err_d = 1'b1;
                        rsp_dat_d = WB_ERR_DATA;
                    end else begin
                        state_d   = ST_ACCESS;
                    end
                end
            end

            ST_ACCESS: begin
                // A master abort takes precedence: nobody is left to ack.
                if (!wbm_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (w_tgt_ack) begin
                    state_d   = ST_RESP;
                    rsp_err_d = 1'b0;
                    rsp_dat_d = ok_rsp_data(we_q, w_tgt_dat);
                end else if (w_tmo_expire) begin
                    state_d   = ST_RESP;
                    rsp_err_d = 1'b1;
                    rsp_dat_d = WB_ERR_DATA;
                end
            end

            ST_RESP: begin
                ack_d   = 1'b1;
                mdat_d  = rsp_dat_q;
                merr_d  = rsp_err_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= ST_IDLE;
            tgt_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            ack_q     <= 1'b0;
            mdat_q    <= '0;
            merr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
            ack_q     <= ack_d;
            mdat_q    <= mdat_d;
            merr_q    <= merr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wbm_ack_o = ack_q;
    assign wbm_dat_o = mdat_q;
    assign wbm_err_o = merr_q;

    // Target strobes follow the registered state, so they are low in reset
    // and drop on the same edge that leaves ACCESS.
    assign wbs_cyc_o = w_in_access ? w_sel_oh : '0;
    assign wbs_stb_o = w_in_access ? w_sel_oh : '0;
    assign wbs_we_o  = we_q;
    assign wbs_sel_o = sel_q;
    assign wbs_adr_o = adr_q;
    assign wbs_dat_o = dat_q;

`ifdef WB_SLAVE_MUX_ERR_LOG_EN
    // ------------------------------------------------------------------
    // Sticky error log: first error after a clear wins. A clear in the
    // same cycle as a new error leaves the new error logged.
    // ------------------------------------------------------------------
    logic        err_vld_q, err_vld_d;
    logic [31:0] err_adr_q, err_adr_d;
    logic        err_typ_q, err_typ_d;
    logic        w_err_dec;
    logic        w_err_tmo;

    assign w_err_dec = (state_q == ST_IDLE) && w_req && w_dec_err;
    assign w_err_tmo = w_in_access && wbm_cyc_i && !w_tgt_ack && w_tmo_expire;

    always_comb begin
        err_vld_d = err_vld_q && !err_clr_i;
        err_adr_d = err_adr_q;
        err_typ_d = err_typ_q;
        if ((w_err_dec || w_err_tmo) && (!err_vld_q || err_clr_i)) begin
            err_vld_d = 1'b1;
            err_adr_d = w_err_dec ? wbm_adr_i : adr_q;
            err_typ_d = w_err_dec ? ERR_TYP_DECODE : ERR_TYP_TMO;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            err_vld_q <= 1'b0;
            err_adr_q <= '0;
            err_typ_q <= 1'b0;
        end else begin
            err_vld_q <= err_vld_d;
            err_adr_q <= err_adr_d;
            err_typ_q <= err_typ_d;
        end
    end

    assign err_vld_o = err_vld_q;
    assign err_adr_o = err_adr_q;
    assign err_typ_o = err_typ_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_slave_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_slave_mux
//  Description : Directed self-checking bench for wb_slave_mux with three
//                targets and an 8-cycle timeout. Targets ack combinationally
//                from their strobe when enabled, which gives best-case
//                latency; a separate vector injects stray acks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_slave_mux;

    localparam int NUM_SLV = 3;
    localparam int TMO     = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   m_cyc, m_stb, m_we;
    logic [3:0]             m_sel;
    logic [31:0]            m_adr, m_dat;
    logic                   wbm_ack_o, wbm_err_o;
    logic [31:0]            wbm_dat_o;
    logic [NUM_SLV-1:0]     wbs_cyc_o, wbs_stb_o;
    logic                   wbs_we_o;
    logic [3:0]             wbs_sel_o;
    logic [31:0]            wbs_adr_o, wbs_dat_o;
    logic [NUM_SLV*32-1:0]  tgt_dat;
    logic [NUM_SLV-1:0]     ack_en, spur, wbs_ack_i;
`ifdef WB_SLAVE_MUX_ERR_LOG_EN
    logic                   err_clr;
    logic                   err_vld_o, err_typ_o;
    logic [31:0]            err_adr_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Results of the last do_req call.
    int                 lat;
    int                 cyc_cycles;
    logic [31:0]        rdat;
    logic               rerr;
    logic [NUM_SLV-1:0] stb_seen;
    logic [31:0]        cap_adr, cap_dat;
    logic [3:0]         cap_sel;
    logic               cap_we;

    always #5 clk = ~clk;

    assign wbs_ack_i = (wbs_stb_o & ack_en) | spur;

    wb_slave_mux #(
        .NUM_SLV   (NUM_SLV),
        .SLV_IDX_W (2),
        .SEL_LSB   (16),
        .BASE_ADDR (8'h30),
        .TMO_CYC   (TMO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .wbm_cyc_i (m_cyc),
        .wbm_stb_i (m_stb),
        .wbm_we_i  (m_we),
        .wbm_sel_i (m_sel),
        .wbm_adr_i (m_adr),
        .wbm_dat_i (m_dat),
        .wbm_ack_o (wbm_ack_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_err_o (wbm_err_o),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_we_o  (wbs_we_o),
        .wbs_sel_o (wbs_sel_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_dat_o (wbs_dat_o),
        .wbs_dat_i (tgt_dat),
        .wbs_ack_i (wbs_ack_i)
`ifdef WB_SLAVE_MUX_ERR_LOG_EN
        ,
        .err_clr_i (err_clr),
        .err_vld_o (err_vld_o),
        .err_adr_o (err_adr_o),
        .err_typ_o (err_typ_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Step one cycle; returns #1 after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request (called #1 after an edge = cycle 0) and wait up to
    // 'limit' cycles for wbm_ack_o. The master drops cyc/stb one edge after
    // it sees ack, as a real Wishbone master does.
    task automatic do_req(input logic [31:0] adr, input logic we,
                          input logic [3:0] sel, input logic [31:0] dat,
                          input int limit);
        logic got;
        got        = 1'b0;
        lat        = 0;
        cyc_cycles = 0;
        rdat       = '0;
        rerr       = 1'b0;
        stb_seen   = '0;
        m_adr = adr; m_we = we; m_sel = sel; m_dat = dat;
        m_cyc = 1'b1; m_stb = 1'b1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            stb_seen = stb_seen | wbs_stb_o;
            if (wbs_cyc_o != '0) cyc_cycles++;
            if (wbs_stb_o != '0) begin
                cap_adr = wbs_adr_o; cap_dat = wbs_dat_o;
                cap_sel = wbs_sel_o; cap_we  = wbs_we_o;
            end
            if (wbm_ack_o) begin
                lat = i; rdat = wbm_dat_o; rerr = wbm_err_o; got = 1'b1;
                break;
            end
        end
        if (got) tick();
        else chk("ack_wait_expired", 32'(lat), 32'(limit));
        m_cyc = 1'b0; m_stb = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        m_cyc = 0; m_stb = 0; m_we = 0; m_sel = '0; m_adr = '0; m_dat = '0;
        ack_en = '1; spur = '0; tgt_dat = '0;
        cap_adr = '0; cap_dat = '0; cap_sel = '0; cap_we = 1'b0;
`ifdef WB_SLAVE_MUX_ERR_LOG_EN
        err_clr = 1'b0;
`endif
        tgt_dat[0*32 +: 32] = 32'hC0DE_0000;
        tgt_dat[1*32 +: 32] = 32'hFFFF_0000;
        tgt_dat[2*32 +: 32] = 32'h1234_5678;

        // ---------------- reset state
        tick(); tick();
        chk("rst_ack", wbm_ack_o, 0);
        chk("rst_mdat", wbm_dat_o, 0);
        chk("rst_err", wbm_err_o, 0);
        chk("rst_cyc_stb", {wbs_cyc_o, wbs_stb_o}, 0);
        chk("rst_req_out", {wbs_we_o, wbs_sel_o, wbs_adr_o[7:0]}, 0);
        rst_n = 1'b1;
        tick();

        // ---------------- read target 2, best-case latency
        do_req(32'h3002_0010, 1'b0, 4'hF, 32'h0, 20);
        chk("rd_lat", 32'(lat), 3);
        chk("rd_dat", rdat, 32'h1234_5678);
        chk("rd_err", rerr, 0);
        chk("rd_stb_seen", stb_seen, 3'b100);
        chk("rd_ack_one_cycle", wbm_ack_o, 0);
        chk("rd_dat_clears", wbm_dat_o, 0);

        // ---------------- write target 1
        do_req(32'h3001_0004, 1'b1, 4'b0011, 32'hA5A5_A5A5, 20);
        chk("wr_lat", 32'(lat), 3);
        chk("wr_tgt_adr", cap_adr, 32'h3001_0004);
        chk("wr_tgt_dat", cap_dat, 32'hA5A5_A5A5);
        chk("wr_tgt_sel_we", {cap_we, cap_sel}, 5'b1_0011);
        chk("wr_stb_seen", stb_seen, 3'b010);
        chk("wr_mdat_zero", rdat, 0);
        chk("wr_err", rerr, 0);
        chk("wr_ack_one_cycle", wbm_ack_o, 0);

        // ---------------- decode errors: wrong window, index beyond NUM_SLV
        do_req(32'h2000_0000, 1'b0, 4'hF, 32'h0, 20);
        chk("dec_base_lat", 32'(lat), 2);
        chk("dec_base_dat", rdat, 32'hDEAD_BEEF);
        chk("dec_base_err", rerr, 1);
        chk("dec_base_stb", stb_seen, 0);
        chk("dec_base_err_clears", wbm_err_o, 0);
        do_req(32'h3003_0000, 1'b0, 4'hF, 32'h0, 20);
        chk("dec_idx_lat", 32'(lat), 2);
        chk("dec_idx_dat", rdat, 32'hDEAD_BEEF);
        chk("dec_idx_err", rerr, 1);
        chk("dec_idx_stb", stb_seen, 0);
`ifdef WB_SLAVE_MUX_ERR_LOG_EN
        chk("log_dec_vld", err_vld_o, 1);
        chk("log_dec_typ", err_typ_o, 0);
        chk("log_dec_first_kept", err_adr_o, 32'h2000_0000);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("log_clr", err_vld_o, 0);
`endif

        // ---------------- timeout on target 0
        ack_en = 3'b000;
        do_req(32'h3000_0040, 1'b0, 4'hF, 32'h0, 30);
        chk("tmo_lat", 32'(lat), TMO + 2);
        chk("tmo_cyc_cycles", 32'(cyc_cycles), TMO);
        chk("tmo_stb_seen", stb_seen, 3'b001);
        chk("tmo_dat", rdat, 32'hDEAD_BEEF);
        chk("tmo_err", rerr, 1);
`ifdef WB_SLAVE_MUX_ERR_LOG_EN
        chk("log_tmo_vld", err_vld_o, 1);
        chk("log_tmo_typ", err_typ_o, 1);
        chk("log_tmo_adr", err_adr_o, 32'h3000_0040);
`endif

        // ---------------- master abort mid-ACCESS
        m_adr = 32'h3000_0000; m_we = 0; m_sel = 4'hF; m_cyc = 1; m_stb = 1;
        tick(); tick();
        chk("abort_cyc_before", wbs_cyc_o, 3'b001);
        m_cyc = 0; m_stb = 0;
        tick();
        chk("abort_cyc_after", {wbs_cyc_o, wbs_stb_o}, 0);
        begin
            int acks = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (wbm_ack_o) acks++;
            end
            chk("abort_no_ack", 32'(acks), 0);
        end

        // ---------------- reset pulse mid-ACCESS
        m_adr = 32'h3000_0000; m_cyc = 1; m_stb = 1;
        tick(); tick();
        chk("rstmid_cyc_before", wbs_cyc_o, 3'b001);
        rst_n = 1'b0;
        #1;
        chk("rstmid_cyc_stb", {wbs_cyc_o, wbs_stb_o}, 0);
        chk("rstmid_adr", wbs_adr_o, 0);
        chk("rstmid_ack_err_dat", {wbm_ack_o, wbm_err_o, wbm_dat_o[29:0]}, 0);
        m_cyc = 0; m_stb = 0;
        tick(); tick();
        rst_n = 1'b1;
        begin
            int acks = 0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (wbm_ack_o) acks++;
            end
            chk("rstmid_no_ack", 32'(acks), 0);
        end
        ack_en = 3'b111;
        do_req(32'h3002_0000, 1'b0, 4'hF, 32'h0, 20);
        chk("post_rst_lat", 32'(lat), 3);
        chk("post_rst_dat", rdat, 32'h1234_5678);

        // ---------------- stray ack from target 1 while target 0 selected
        ack_en = 3'b000; spur = 3'b010;
        m_adr = 32'h3000_0008; m_we = 0; m_sel = 4'hF; m_cyc = 1; m_stb = 1;
        tick(); tick(); tick();
        chk("spur_ignored", wbm_ack_o, 0);
        chk("spur_still_access", wbs_cyc_o, 3'b001);
        ack_en = 3'b001;
        tick();
        chk("spur_no_early_ack", wbm_ack_o, 0);
        tick();
        chk("spur_ack", wbm_ack_o, 1);
        chk("spur_dat", wbm_dat_o, 32'hC0DE_0000);
        chk("spur_err", wbm_err_o, 0);
        tick();
        m_cyc = 0; m_stb = 0; spur = '0; ack_en = 3'b111;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
